uart_host_link: RTL and testbench

- Synthesizable host-side peer for the UART demo.
- Accepts one request byte on a valid/ready handshake and transmits it as an 8N1 frame on uart_txd.
- Then waits for a single response byte on uart_rxd and returns it, or flags a timeout or framing error.
- Used in the board-to-board link and as the stimulus engine in demo system simulation.

---
 rtl/uart_host_link.sv | 178 +++++++++++++++++
 tb/tb_uart_host_link.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_host_link.sv
// uart_host_link: host-side UART peer; sends one request byte and returns one response byte.
// 8N1 by default; define UART_HOST_PARITY_EN for 8E1 with parity check.
module uart_host_link #(
    parameter int BAUDRATE      = 115200,
    parameter int CLK_FREQ      = 100000000,
    parameter int TIMEOUT_BAUDS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_byte,
    output logic       rsp_valid,
    output logic [7:0] rsp_byte,
    output logic       rsp_timeout,
    output logic       rsp_frame_err,
    output logic       rsp_parity_err,
    output logic       uart_txd,
    input  logic       uart_rxd
);
    localparam int DIV = CLK_FREQ / BAUDRATE;
    localparam int CW  = $clog2(DIV);
    localparam int TW  = $clog2(TIMEOUT_BAUDS + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_BAUDS - 1);

    typedef enum logic [3:0] {
        IDLE, TX_START, TX_DATA,
`ifdef UART_HOST_PARITY_EN
        TX_PAR, RX_PAR,
`endif
        TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;
    logic          rx_s1, rx_s2, rx_prev;
    logic          bit_end;
    logic          rx_fall;

    assign bit_end = baud_cnt == BIT_END;
    assign rx_fall = rx_prev & ~rx_s2;

    always_ff @(posedge clk or posedge rst)
        if (rst) {rx_s1, rx_s2, rx_prev} <= 3'b111;
        else {rx_s1, rx_s2, rx_prev} <= {uart_rxd, rx_s1, rx_s2};

`ifdef UART_HOST_PARITY_EN
    logic tx_par;
    logic par_err;
`else
    assign rsp_parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            tmo_cnt       <= '0;
            bit_cnt       <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            uart_txd      <= 1'b1;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_byte      <= '0;
            rsp_timeout   <= 1'b0;
            rsp_frame_err <= 1'b0;
`ifdef UART_HOST_PARITY_EN
            tx_par         <= 1'b0;
            par_err        <= 1'b0;
            rsp_parity_err <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            baud_cnt  <= bit_end ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (req_valid) begin
                        state         <= TX_START;
                        tx_shift      <= req_byte;
                        uart_txd      <= 1'b0;
                        req_ready     <= 1'b0;
                        bit_cnt       <= '0;
                        tmo_cnt       <= '0;
                        rsp_timeout   <= 1'b0;
                        rsp_frame_err <= 1'b0;
`ifdef UART_HOST_PARITY_EN
                        tx_par         <= ^req_byte;
                        par_err        <= 1'b0;
                        rsp_parity_err <= 1'b0;
`endif
                    end
                end
                TX_START: if (bit_end) begin
                    state    <= TX_DATA;
                    uart_txd <= tx_shift[0];
                end
                TX_DATA: if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_HOST_PARITY_EN
                        state    <= TX_PAR;
                        uart_txd <= tx_par;
`else
                        state    <= TX_STOP;
                        uart_txd <= 1'b1;
`endif
                    end else begin
                        bit_cnt  <= bit_cnt + 1'b1;
                        uart_txd <= tx_shift[1];
                        tx_shift <= tx_shift >> 1;
                    end
                end
`ifdef UART_HOST_PARITY_EN
                TX_PAR: if (bit_end) begin
                    state    <= TX_STOP;
                    uart_txd <= 1'b1;
                end
                RX_PAR: if (bit_end) begin
                    state   <= RX_STOP;
                    par_err <= rx_s2 ^ (^rx_shift);
                end
`endif
                TX_STOP: if (bit_end) begin
                    state   <= RX_WAIT;
                    tmo_cnt <= '0;
                end
                RX_WAIT:
                    if (rx_fall) begin
                        state    <= RX_START;
                        baud_cnt <= '0;
                    end else if (bit_end) begin
                        if (tmo_cnt == TMO_END) begin
                            state       <= DONE;
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_byte    <= '0;
                        end else tmo_cnt <= tmo_cnt + 1'b1;
                    end
                // a start bit that is no longer low at mid-bit was a glitch; keep the timeout running
                RX_START: if (baud_cnt == HALF_END) begin
                    state    <= rx_s2 ? RX_WAIT : RX_DATA;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                RX_DATA: if (bit_end) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    bit_cnt  <= bit_cnt + 1'b1;
`ifdef UART_HOST_PARITY_EN
                    if (bit_cnt == 3'd7) state <= RX_PAR;
`else
                    if (bit_cnt == 3'd7) state <= RX_STOP;
`endif
                end
                RX_STOP: if (bit_end) begin
                    state         <= DONE;
                    rsp_valid     <= 1'b1;
                    rsp_byte      <= rx_shift;
                    rsp_frame_err <= ~rx_s2;
`ifdef UART_HOST_PARITY_EN
                    rsp_parity_err <= par_err;
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    baud_cnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_host_link.sv
// tb_uart_host_link: directed plus randomized transactions against a frame-level reference model.
module tb_uart_host_link;
    localparam int DIV = 10;
    localparam int TMO = 32;
`ifdef UART_HOST_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 10 + PAR;

    logic       clk, rst, req_valid, req_ready, rsp_valid;
    logic       rsp_timeout, rsp_frame_err, rsp_parity_err, uart_txd, uart_rxd;
    logic [7:0] req_byte, rsp_byte;

    uart_host_link #(.BAUDRATE(10000000), .CLK_FREQ(100000000), .TIMEOUT_BAUDS(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_byte(req_byte),
        .rsp_valid(rsp_valid), .rsp_byte(rsp_byte), .rsp_timeout(rsp_timeout),
        .rsp_frame_err(rsp_frame_err), .rsp_parity_err(rsp_parity_err),
        .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    int n_cmp = 0, n_err = 0;
    int cyc = 0, rsp_cnt = 0, cap_cyc = 0;
    logic [7:0] cap_byte;
    logic cap_tmo, cap_fe, cap_pe;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (rsp_valid) begin
            rsp_cnt  <= rsp_cnt + 1;
            cap_cyc  <= cyc;
            cap_byte <= rsp_byte;
            cap_tmo  <= rsp_timeout;
            cap_fe   <= rsp_frame_err;
            cap_pe   <= rsp_parity_err;
        end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic accept(input logic [7:0] tx, output int acc);
        int t0;
        t0 = cyc;
        @(negedge clk);
        while (!req_ready && cyc < t0 + 2000) @(negedge clk);
        chk("req_ready_wait", req_ready, 1);
        req_byte  = tx;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        acc = cyc;
        chk("req_ready_drop", req_ready, 0);
    endtask

    // Serial frame on uart_rxd: start, data LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] rx, input bit bad_stop, input bit bad_par, output int drv);
        logic [10:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[1+i] = rx[i];
        if (PAR == 1) b[9] = (^rx) ^ bad_par;
        b[NB-1] = ~bad_stop;
        drv = cyc;
        for (int k = 0; k < NB; k++) begin
            uart_rxd = b[k];
            repeat (DIV) @(negedge clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic do_txn(input logic [7:0] tx, input bit reply, input logic [7:0] rx,
                          input bit bad_stop, input bit bad_par, input int gap, input bit glitch);
        int acc, n0, drv;
        logic [10:0] got, exp;
        n0 = rsp_cnt;
        accept(tx, acc);
        chk("flags_cleared", {rsp_timeout, rsp_frame_err, rsp_parity_err}, 0);
        exp = '0;
        got = '0;
        for (int i = 0; i < 8; i++) exp[1+i] = tx[i];
        if (PAR == 1) exp[9] = ^tx;
        exp[NB-1] = 1'b1;
        for (int k = 0; k < NB; k++) begin
            wait_cyc(acc + k * DIV + DIV / 2 - 1);
            got[k] = uart_txd;
        end
        chk("tx_frame", got, exp);
        if (glitch) begin
            wait_cyc(acc + NB * DIV + DIV);
            uart_rxd = 1'b0;
            repeat (3) @(negedge clk);
            uart_rxd = 1'b1;
        end
        if (reply) begin
            wait_cyc(acc + NB * DIV + gap);
            send_frame(rx, bad_stop, bad_par, drv);
        end
        while (rsp_cnt == n0 && cyc < acc + 2000) @(negedge clk);
        chk("rsp_seen", rsp_cnt > n0, 1);
        repeat (5) @(negedge clk);
        chk("rsp_single_pulse", rsp_cnt - n0, 1);
        chk("rsp_byte", cap_byte, reply ? rx : 8'h00);
        chk("rsp_timeout", cap_tmo, !reply);
        chk("rsp_frame_err", cap_fe, reply && bad_stop);
        chk("rsp_parity_err", cap_pe, reply && bad_par && PAR == 1);
        chk("rsp_byte_hold", rsp_byte, reply ? rx : 8'h00);
        chk("req_ready_back", req_ready, 1);
        // start drive is half a clock before the first sync edge, hence the extra 1
        if (reply) chk("rx_latency", cap_cyc - drv, 1 + 2 + DIV / 2 + (9 + PAR) * DIV);
        else chk("tmo_latency", cap_cyc - (acc + NB * DIV), TMO * DIV);
    endtask

    initial begin
        int acc, n0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_byte = '0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", uart_txd, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_byte", rsp_byte, 0);
        chk("rst_flags", {rsp_timeout, rsp_frame_err, rsp_parity_err}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_txn(8'hA5, 1, 8'h3C, 0, 0, 2 * DIV, 0);
        do_txn(8'h00, 0, 8'h00, 0, 0, 0, 0);
        do_txn(8'($urandom), 1, 8'h55, 1, 0, 15, 0);
        do_txn(8'($urandom), 1, 8'h81, 0, 0, 3 * DIV, 1);

        n0 = rsp_cnt;
        accept(8'hF0, acc);
        wait_cyc(acc + 4 * DIV + DIV / 2 - 1);
        chk("pre_rst_txd", uart_txd, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_txd", uart_txd, 1);
        chk("async_rst_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        chk("rst_no_rsp", rsp_cnt - n0, 0);
        do_txn(8'h12, 1, 8'($urandom), 0, 0, 25, 0);

`ifdef UART_HOST_PARITY_EN
        do_txn(8'h07, 1, 8'h01, 0, 1, 2 * DIV, 0);
`endif
        for (int t = 0; t < 6; t++)
            do_txn(8'($urandom), $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                   PAR == 1 && $urandom_range(0, 2) == 0, $urandom_range(1, 150), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
